// File: rtl/resize_axis_pkg.sv
// Shared width derivations, channel slicing and the output round/saturate rule
// for the resize interpolation MAC.
package resize_axis_pkg;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  function automatic int acc_width(input int a_w, input int b_w, input int max_taps);
    return prod_width(a_w, b_w) + $clog2(max_taps);
  endfunction

  function automatic int chan_lo(input int chan, input int width);
    return chan * width;
  endfunction

  // Round half up, drop the fraction, clamp into [0, 2^out_width-1].
  function automatic logic [31:0] round_sat(input logic signed [63:0] acc,
                                            input int frac_bits, input int out_width);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    r     = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    max_v = (64'sd1 <<< out_width) - 64'sd1;
    if (r < 0)
      return 32'd0;
    else if (r > max_v)
      return 32'(max_v);
    else
      return 32'(r);
  endfunction

endpackage

// File: rtl/resize_axis_mul_su_pipe.sv
// One-channel registered signed-weight x unsigned-pixel multiplier; the product
// register is sized so a single DSP slice absorbs it.
module resize_axis_mul_su_pipe
  import resize_axis_pkg::*;
#(
  parameter int A_WIDTH = 20,
  parameter int B_WIDTH = 8
) (
  input  logic                                        ap_clk,
  input  logic                                        i_en,
  input  logic signed [A_WIDTH-1:0]                   i_a,
  input  logic        [B_WIDTH-1:0]                   i_b,
  output logic signed [prod_width(A_WIDTH,B_WIDTH)-1:0] o_p
);

  localparam int PROD_WIDTH = prod_width(A_WIDTH, B_WIDTH);

  logic signed [PROD_WIDTH-1:0] r_p;

  // No reset: the stage valid travelling alongside qualifies this register.
  always_ff @(posedge ap_clk) begin
    if (i_en)
      r_p <= i_a * $signed({1'b0, i_b});
  end

  assign o_p = r_p;

endmodule

// File: rtl/resize_axis_interp_mac.sv
// Four-stage multi-channel tap MAC: register taps, multiply, accumulate per
// group, then round/saturate into the output register with ready/valid.
module resize_axis_interp_mac
  import resize_axis_pkg::*;
#(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 8,
  parameter int CHANNELS  = 3,
  parameter int MAX_TAPS  = 4,
  parameter int FRAC_BITS = 14,
  parameter int OUT_WIDTH = 8
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [A_WIDTH-1:0]     s_a,
  input  logic [CHANNELS*B_WIDTH-1:0]   s_b,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CHANNELS*OUT_WIDTH-1:0] m_data,
  output logic                          err_taps
);

  localparam int PROD_WIDTH = prod_width(A_WIDTH, B_WIDTH);
  localparam int ACC_WIDTH  = acc_width(A_WIDTH, B_WIDTH, MAX_TAPS);
  localparam int CNT_WIDTH  = $clog2(MAX_TAPS + 2);

  logic                          w_en;
  logic                          r_s1_valid;
  logic                          r_s1_last;
  logic signed [A_WIDTH-1:0]     r_s1_a;
  logic [CHANNELS*B_WIDTH-1:0]   r_s1_b;
  logic                          r_s2_valid;
  logic                          r_s2_last;
  logic                          r_first;
  logic                          r_s3_done;
  logic [CNT_WIDTH-1:0]          r_tap_cnt;
  logic [CNT_WIDTH-1:0]          w_cnt_next;
  logic                          r_err_taps;
  logic                          r_m_valid;

  assign w_en     = !r_m_valid || m_ready;
  assign s_ready  = w_en;
  assign m_valid  = r_m_valid;
  assign err_taps = r_err_taps;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= s_valid;
      r_s1_last  <= s_last;
      r_s1_a     <= s_a;
      r_s1_b     <= s_b;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
    end
  end

  // Tap count saturates one past the limit so it can never wrap back to legal.
  always_comb begin
    w_cnt_next = r_tap_cnt + CNT_WIDTH'(1);
    if (r_first)
      w_cnt_next = CNT_WIDTH'(1);
    else if (r_tap_cnt == CNT_WIDTH'(MAX_TAPS + 1))
      w_cnt_next = r_tap_cnt;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_first    <= 1'b1;
      r_s3_done  <= 1'b0;
      r_tap_cnt  <= '0;
      r_err_taps <= 1'b0;
      r_m_valid  <= 1'b0;
    end else if (w_en) begin
      r_s3_done <= r_s2_valid && r_s2_last;
      r_m_valid <= r_s3_done;
      if (r_s2_valid) begin
        r_first   <= r_s2_last;
        r_tap_cnt <= w_cnt_next;
        if (w_cnt_next == CNT_WIDTH'(MAX_TAPS + 1))
          r_err_taps <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic signed [PROD_WIDTH-1:0] w_p;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic [31:0]                  w_rs;
    logic [OUT_WIDTH-1:0]         r_out;

    resize_axis_mul_su_pipe #(
      .A_WIDTH (A_WIDTH),
      .B_WIDTH (B_WIDTH)
    ) u_mul (
      .ap_clk (ap_clk),
      .i_en   (w_en),
      .i_a    (r_s1_a),
      .i_b    (r_s1_b[chan_lo(gi, B_WIDTH) +: B_WIDTH]),
      .o_p    (w_p)
    );

    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n)
        r_acc <= '0;
      else if (w_en && r_s2_valid)
        r_acc <= (r_first ? ACC_WIDTH'(0) : r_acc) + ACC_WIDTH'(w_p);
    end

    assign w_rs = round_sat(64'(r_acc), FRAC_BITS, OUT_WIDTH);

    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n)
        r_out <= '0;
      else if (w_en && r_s3_done)
        r_out <= OUT_WIDTH'(w_rs);
    end

    assign m_data[chan_lo(gi, OUT_WIDTH) +: OUT_WIDTH] = r_out;
  end

endmodule

// File: tb/tb_resize_axis_interp_mac.sv
// Randomised bench for resize_axis_interp_mac: a per-group arithmetic model
// predicts every output vector, and scenario tasks check flow control and flags.
module tb_resize_axis_interp_mac;

  localparam int AW = 20;
  localparam int BW = 8;
  localparam int CH = 3;
  localparam int MT = 4;
  localparam int FB = 14;
  localparam int OW = 8;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst_n = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [AW-1:0] s_a = '0;
  logic [CH*BW-1:0]     s_b = '0;
  logic                 s_last = 1'b0;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic [CH*OW-1:0]     m_data;
  logic                 err_taps;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [CH*OW-1:0] exp_q[$];
  bit               dc_q[$];
  logic [CH*OW-1:0] rcv_q[$];
  longint           g_acc[CH];
  int               g_taps = 0;

  resize_axis_interp_mac #(
    .A_WIDTH(AW), .B_WIDTH(BW), .CHANNELS(CH),
    .MAX_TAPS(MT), .FRAC_BITS(FB), .OUT_WIDTH(OW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_taps(err_taps)
  );

  always #5 ap_clk = ~ap_clk;

  // Inputs change only #1 after a rising edge, so a negedge sample predicts the next edge.
  always @(negedge ap_clk)
    if (ap_rst_n && m_valid && m_ready)
      rcv_q.push_back(m_data);

  task automatic model_clear();
    for (int c = 0; c < CH; c++) g_acc[c] = 0;
    g_taps = 0;
  endtask

  task automatic model_tap(input int w, input logic [CH*BW-1:0] b, input bit last);
    logic [CH*OW-1:0] vec;
    longint r;
    for (int c = 0; c < CH; c++)
      g_acc[c] += longint'(w) * longint'(b[c*BW +: BW]);
    g_taps++;
    if (last) begin
      vec = '0;
      for (int c = 0; c < CH; c++) begin
        r = (g_acc[c] + (longint'(1) <<< (FB - 1))) >>> FB;
        if (r < 0) r = 0;
        if (r > (1 << OW) - 1) r = (1 << OW) - 1;
        vec[c*OW +: OW] = OW'(r);
      end
      exp_q.push_back(vec);
      dc_q.push_back(g_taps > MT);
      model_clear();
    end
  endtask

  task automatic drive_tap(input int w, input logic [CH*BW-1:0] b, input bit last);
    bit rdy;
    int n;
    s_valid = 1'b1;
    s_a     = AW'(w);
    s_b     = b;
    s_last  = last;
    n = 0;
    do begin
      @(negedge ap_clk);
      rdy = s_ready;
      @(posedge ap_clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    n_cmp++;
    if (!rdy) begin
      n_fail++;
      $display("FAIL tap_accept_timeout got s_ready=0 for %0d cycles want accept", n);
    end else begin
      model_tap(w, b, last);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic rand_pix(output logic [CH*BW-1:0] b);
    for (int c = 0; c < CH; c++) b[c*BW +: BW] = BW'($urandom_range(0, 255));
  endtask

  task automatic wait_drain(output bit ok);
    int n;
    n = 0;
    while (rcv_q.size() < exp_q.size() && n < 400) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    ok = (rcv_q.size() >= exp_q.size());
  endtask

  task automatic wait_mvalid(output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!m_valid && n < 20);
    ok = m_valid;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    m_ready  = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    n_cmp += 4;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data got %h want 0", m_data); end
    if (err_taps !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_taps); end
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    ap_rst_n = 1'b1;
    model_clear();
    exp_q.delete(); dc_q.delete(); rcv_q.delete();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_basic();
    int pix[4] = '{100, 200, 50, 150};
    logic [CH*BW-1:0] b;
    logic [CH*OW-1:0] e, r;
    bit ok, d;
    for (int t = 0; t < 4; t++) begin
      rand_pix(b);
      b[BW-1:0] = BW'(pix[t]);
      drive_tap(4096, b, t == 3);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      n_cmp++;
      if (m_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL latency_edge%0d got m_valid=%b want %b", i, m_valid, (i == 3));
      end
    end
    n_cmp++;
    if (m_data[OW-1:0] !== 8'd125) begin
      n_fail++;
      $display("FAIL basic_ch0 got %0d want 125", m_data[OW-1:0]);
    end
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL basic_drain got %0d outputs want %0d", rcv_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      e = exp_q.pop_front(); d = dc_q.pop_front(); r = rcv_q.pop_front();
      if (!d) begin
        n_cmp++;
        if (r !== e) begin n_fail++; $display("FAIL basic_vec got %h want %h", r, e); end
      end
    end
  endtask

  task automatic test_round_sat();
    int wv[4] = '{-16384, 32768, 8192, 8192};
    int pv[4] = '{10, 200, 3, 1};
    int ev[4] = '{0, 255, 2, 1};
    logic [CH*BW-1:0] b;
    logic [CH*OW-1:0] e, r;
    bit ok, d;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < CH; c++) b[c*BW +: BW] = BW'(pv[k]);
      drive_tap(wv[k], b, 1'b1);
      wait_mvalid(ok);
      n_cmp++;
      if (!ok || m_data[OW-1:0] !== OW'(ev[k])) begin
        n_fail++;
        $display("FAIL round_sat_%0d got %0d (valid=%b) want %0d", k, m_data[OW-1:0], m_valid, ev[k]);
      end
      @(posedge ap_clk);
      #1;
    end
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL round_drain got %0d outputs want %0d", rcv_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      e = exp_q.pop_front(); d = dc_q.pop_front(); r = rcv_q.pop_front();
      if (!d) begin
        n_cmp++;
        if (r !== e) begin n_fail++; $display("FAIL round_vec got %h want %h", r, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [CH*OW-1:0] e, r, hold;
    bit ok, d;
    fork
      begin
        logic [CH*BW-1:0] b;
        for (int g = 0; g < 6; g++)
          for (int t = 0; t < 3; t++) begin
            rand_pix(b);
            drive_tap($urandom_range(0, 49152) - 16384, b, t == 2);
          end
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge ap_clk);
          #1;
          n++;
        end while (!m_valid && n < 40);
        m_ready = 1'b0;
        hold = m_data;
        for (int i = 0; i < 5; i++) begin
          @(negedge ap_clk);
          n_cmp += 3;
          if (s_ready !== 1'b0) begin n_fail++; $display("FAIL stall_s_ready cycle %0d got %b want 0", i, s_ready); end
          if (m_valid !== 1'b1) begin n_fail++; $display("FAIL stall_m_valid cycle %0d got %b want 1", i, m_valid); end
          if (m_data !== hold) begin n_fail++; $display("FAIL stall_m_data cycle %0d got %h want %h", i, m_data, hold); end
        end
        @(posedge ap_clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL b2b_drain got %0d outputs want %0d", rcv_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      e = exp_q.pop_front(); d = dc_q.pop_front(); r = rcv_q.pop_front();
      if (!d) begin
        n_cmp++;
        if (r !== e) begin n_fail++; $display("FAIL b2b_vec got %h want %h", r, e); end
      end
    end
  endtask

  task automatic test_reset_mid_group();
    int pix[2] = '{40, 60};
    logic [CH*BW-1:0] b;
    logic [CH*OW-1:0] e, r;
    bit ok, d;
    for (int t = 0; t < 2; t++) begin
      rand_pix(b);
      drive_tap($urandom_range(0, 32768), b, 1'b0);
    end
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    model_clear();
    rcv_q.delete();
    n_cmp += 2;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid got %b want 0", m_valid); end
    if (err_taps !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %b want 0", err_taps); end
    for (int t = 0; t < 2; t++) begin
      rand_pix(b);
      b[BW-1:0] = BW'(pix[t]);
      drive_tap(8192, b, t == 1);
    end
    wait_mvalid(ok);
    n_cmp += 2;
    if (!ok || m_data[OW-1:0] !== 8'd50) begin
      n_fail++;
      $display("FAIL midrst_ch0 got %0d (valid=%b) want 50", m_data[OW-1:0], m_valid);
    end
    if (err_taps !== 1'b0) begin n_fail++; $display("FAIL midrst_err_after got %b want 0", err_taps); end
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL midrst_drain got %0d outputs want %0d", rcv_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      e = exp_q.pop_front(); d = dc_q.pop_front(); r = rcv_q.pop_front();
      if (!d) begin
        n_cmp++;
        if (r !== e) begin n_fail++; $display("FAIL midrst_vec got %h want %h", r, e); end
      end
    end
  endtask

  task automatic test_err_taps();
    logic [CH*BW-1:0] b;
    logic [CH*OW-1:0] e, r;
    bit ok, d;
    for (int t = 0; t < 4; t++) begin
      rand_pix(b);
      drive_tap($urandom_range(0, 16384), b, 1'b0);
    end
    repeat (4) @(posedge ap_clk);
    #1;
    n_cmp++;
    if (err_taps !== 1'b0) begin n_fail++; $display("FAIL err_at_4_taps got %b want 0", err_taps); end
    rand_pix(b);
    drive_tap($urandom_range(0, 16384), b, 1'b1);
    repeat (4) @(posedge ap_clk);
    #1;
    n_cmp++;
    if (err_taps !== 1'b1) begin n_fail++; $display("FAIL err_at_5_taps got %b want 1", err_taps); end
    for (int t = 0; t < 4; t++) begin
      rand_pix(b);
      drive_tap($urandom_range(0, 49152) - 16384, b, t == 3);
    end
    wait_drain(ok);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("FAIL err_drain got %0d outputs want %0d", rcv_q.size(), exp_q.size()); end
    if (err_taps !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err_taps); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      e = exp_q.pop_front(); d = dc_q.pop_front(); r = rcv_q.pop_front();
      if (!d) begin
        n_cmp++;
        if (r !== e) begin n_fail++; $display("FAIL err_next_vec got %h want %h", r, e); end
      end
    end
  endtask

  task automatic test_random();
    logic [CH*OW-1:0] e, r;
    bit ok, d, stop;
    stop = 1'b0;
    fork
      begin
        logic [CH*BW-1:0] b;
        int nt;
        for (int g = 0; g < 25; g++) begin
          nt = $urandom_range(1, MT);
          for (int t = 0; t < nt; t++) begin
            rand_pix(b);
            drive_tap($urandom_range(0, 49152) - 16384, b, t == nt - 1);
            repeat ($urandom_range(0, 2)) begin @(posedge ap_clk); #1; end
          end
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge ap_clk);
          #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL rand_drain got %0d outputs want %0d", rcv_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      e = exp_q.pop_front(); d = dc_q.pop_front(); r = rcv_q.pop_front();
      if (!d) begin
        n_cmp++;
        if (r !== e) begin n_fail++; $display("FAIL rand_vec got %h want %h", r, e); end
      end
    end
    repeat (20) @(posedge ap_clk);
    #1;
    n_cmp++;
    if (rcv_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_outputs got %0d extra/%0d missing want 0/0", rcv_q.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_sat();
    test_back_to_back();
    test_reset_mid_group();
    test_random();
    test_err_taps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/resize_axis_interp_mac.md
Name: resize_axis_interp_mac

Overview:
Pipelined, multi-channel, signed-weight × unsigned-pixel multiply-accumulate for the resize datapath. It takes a stream of (weight, pixel-vector) taps and accumulates each group of taps per channel. At the end of a group it rounds, right-shifts by FRAC_BITS, saturates to the pixel range and emits one output pixel vector. It sits between the tap-fetch logic and the AXIS output packer, using ready/valid flow control on both sides.

Parameters:
A_WIDTH, 20, signed weight width, fixed-point with FRAC_BITS fraction bits.
B_WIDTH, 8, unsigned pixel component width.
CHANNELS, 3, pixel components processed in parallel; all share one weight.
MAX_TAPS, 4, maximum taps per group that the accumulator is sized for.
FRAC_BITS, 14, weight fraction bits; 1.0 = 2^FRAC_BITS.
OUT_WIDTH, 8, unsigned output component width.

Ports:
ap_clk  in  1  clock; all logic on rising edge.
ap_rst_n  in  1  synchronous reset, active-low.
s_valid  in  1  input tap valid.
s_ready  out  1  input tap accepted when s_valid && s_ready.
s_a  in  A_WIDTH  signed weight for this tap.
s_b  in  CHANNELS*B_WIDTH  unsigned pixel components; channel c at [c*B_WIDTH +: B_WIDTH].
s_last  in  1  final tap of the current group.
m_valid  out  1  output vector valid.
m_ready  in  1  downstream accept.
m_data  out  CHANNELS*OUT_WIDTH  rounded, saturated result; channel c at [c*OUT_WIDTH +: OUT_WIDTH].
err_taps  out  1  sticky: a group exceeded MAX_TAPS taps.

Behaviour:
- Reset (ap_rst_n low at an edge): m_valid=0, m_data=0, err_taps=0, all stage valids=0, accumulators=0, tap counter=0, first-tap flag=1. Any partial group is discarded; the first accepted tap after reset starts a new group.
- Pipeline enable: en = !m_valid || m_ready. s_ready = en. Every stage holds its contents when en=0. No combinational path exists from s_valid to s_ready.
- Stages, all advanced by en:
  - S1 registers s_a, s_b, s_last and the accept flag.
  - S2 registers p[c] = signed(a) × signed({1'b0, b[c]}), A_WIDTH+B_WIDTH+1 bits.
  - S3 accumulator: acc[c] = (first ? 0 : acc[c]) + sext(p[c]). ACC_WIDTH = A_WIDTH+B_WIDTH+1+clog2(MAX_TAPS). first is cleared after any valid tap and set after a tap with last. S3 flags "done" when the tap carried last.
  - S4 output register: if S3 done, m_data[c] = sat(round(acc[c])) and m_valid=1. Otherwise m_valid=0.
- Latency: a last tap accepted at edge k gives m_valid=1 after edge k+3. Throughput is one tap per cycle with no bubbles between groups.
- Rounding: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, round half up). Saturation: r<0 → 0; r>2^OUT_WIDTH-1 → 2^OUT_WIDTH-1.
- Tap counter counts taps in the current group. If it would reach MAX_TAPS+1, err_taps is set and stays set until reset. Accumulation continues; the result of that group is unspecified but is still emitted.
- A 1-tap group (s_last on the first tap) is legal.
- s_valid low mid-group inserts bubbles only; the accumulator holds its value.
- While m_valid && !m_ready, m_data is stable, s_ready=0, and the pipeline is frozen.

Decomposition:
- Package resize_axis_pkg holds the ACC_WIDTH/PROD_WIDTH derivation functions, the round_sat function (acc, FRAC_BITS, OUT_WIDTH), and the channel slice helpers.
- One sub-module, resize_axis_mul_su_pipe, implements the one-channel registered signed×unsigned multiplier with an enable input. It is instantiated CHANNELS times, so a DSP48 is inferred per channel.

Test Plan:
- CHANNELS=3, 4 taps of weight 4096; channel 0 pixels 100, 200, 50, 150 → m_data ch0 = 125. m_valid appears 3 edges after the last-tap accept.
- Single tap, weight -16384, pixel 10, last → 0 (negative saturation). Weight 32768, pixel 200 → 255 (positive saturation).
- Weight 8192, pixel 3, last → 2 (1.5 rounds up). Weight 8192, pixel 1 → 1 (0.5 rounds up).
- Back-to-back groups at full rate with m_ready held low 5 cycles mid-stream → s_ready low for those cycles, m_data stable, no taps lost or duplicated, outputs in order.
- Reset asserted after 2 of 4 taps, then a fresh 2-tap group of weight 8192 with pixels 40, 60 → output 50. The partial group does not contaminate the result, and err_taps=0.
- MAX_TAPS=4; a 5-tap group → err_taps=1 after the 5th accept and stays 1. A following valid 4-tap group is still emitted correctly.
